demux_one_to_two_reg: RTL and testbench
=======================================

# demux_one_to_two_reg

Registered 1-to-2 demultiplexer with a valid/ready handshake. It routes each 32-bit word from a single producer to one of two consumers, selected per word by `in_sel`. It is the inverse of the datapath 2:1 mux and is used where one result stream must be steered to two downstream units, for example the write-back path versus the forwarding path. Each output port has its own one-entry holding register, so a stalled consumer does not block words bound for the other port.

## Interface
- `WIDTH`, default 32: data width of the input and both output ports.
- `CNT_W`, default 16: width of the per-port transfer counters.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_data`  input  WIDTH  word to route.
- `in_sel`  input  1  destination: 0 selects port 0, 1 selects port 1. In simulation, X or Z is treated as 0.
- `in_ready`  output  1  the word is accepted this cycle if `in_valid` is also 1.
- `out0_valid`  output  1  port 0 holds a word.
- `out0_data`  output  WIDTH  port 0 word.
- `out0_ready`  input  1  consumer 0 accepts this cycle.
- `out1_valid`, `out1_data`, `out1_ready`: same as port 0, for port 1.
- `cnt0`  output  CNT_W  number of words delivered on port 0 (`out0_valid && out0_ready`).
- `cnt1`  output  CNT_W  number of words delivered on port 1.

## Operation
- Each port is a 1-entry slot with two states:
  - EMPTY: `outN_valid` = 0.
  - FULL: `outN_valid` = 1, and `outN_data` is stable while the port stays FULL.
- `in_ready` is combinational:
  - `in_sel` = 0: `in_ready` = `!out0_valid || out0_ready`.
  - `in_sel` = 1: `in_ready` = `!out1_valid || out1_ready`.
  - `in_ready` never depends on `in_valid`.
- Accept means `in_valid && in_ready` at the rising edge. On accept, the selected slot loads `in_data` and is FULL next cycle.
- Drain means `outN_valid && outN_ready`. On drain with no load that cycle, slot N goes EMPTY.
- Drain and load on the same slot in the same cycle: the slot stays FULL and holds the new word. This gives no bubble, one word per cycle per port.
- The non-selected port drains independently in the same cycle.
- No word is ever duplicated, dropped, or sent to the wrong port.
- Words to the same port leave in acceptance order. No ordering is guaranteed between ports.
- Counters:
  - `cntN` increments by 1 on each drain of port N.
  - Arithmetic is modulo 2^CNT_W, so all-ones wraps to 0.
  - Counters have no enable or clear other than `rst`.

## Timing
- Reset values:
  - `out0_valid` = `out1_valid` = 0.
  - `out0_data` = `out1_data` = 0.
  - `cnt0` = `cnt1` = 0.
  - `in_ready` = 1 (both slots empty).
- Reset assertion mid-operation clears both slots immediately, asynchronously. Held words are discarded, not delivered.
- After `rst` deasserts, the first accept can happen at the first rising edge.
- Latency: a word accepted at edge k is visible with `outN_valid` = 1 from just after edge k until the edge where it drains. Minimum residence is 1 cycle.
- Throughput: 1 word per cycle total. Each port sustains 1/cycle while its consumer holds ready high.
- `outN_data` changes only on a load. It is not cleared on drain.
- Combinational paths: `outN_ready` → `in_ready` and `in_sel` → `in_ready`. No path runs from any input to `outN_valid`, `outN_data`, or `cntN`.

## Test plan
- **Reset:** assert `rst` for 3 cycles, then release with no traffic. Required: all outputs 0 and `in_ready` = 1. Assert `rst` while port 1 is FULL with 0xDEADBEEF. Required: `out1_valid` falls without waiting for `clk`, and the word never appears.
- **Steering:** send 0x11111111 (sel 0), 0x22222222 (sel 1), 0x33333333 (sel 0) with both readies high. Required: port 0 delivers 0x11111111 then 0x33333333, port 1 delivers 0x22222222, `cnt0` = 2, `cnt1` = 1.
- **Back-pressure isolation:** hold `out0_ready` = 0 with port 0 FULL. Required: `in_ready` = 0 while `in_sel` = 0 and 1 while `in_sel` = 1. A word sent to port 1 (0xA5A5A5A5) is delivered, and port 0's word is unchanged.
- **Same-cycle drain and load:** stream 8 consecutive words to port 1 with `out1_ready` = 1. Required: `out1_valid` stays high for 8 consecutive cycles, the words arrive in order, and `in_ready` is never 0.
- **Counter wrap:** deliver 65,535 words on port 0, then one more. Required: `cnt0` goes 0xFFFF → 0x0000, and `cnt1` is unchanged.
- **X select (simulation):** drive `in_sel` = X with `in_valid` = 1 and data 0x0BADF00D. Required: the word lands on port 0, and port 1 is untouched.

Source files
------------

// File: rtl/demux_one_to_two_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake.
// Each port owns a one-entry slot, so a stalled consumer never blocks the other port.
module demux_one_to_two_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic slot_free;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // Steering: an unknown select falls into the else branch, i.e. port 0.
    always_comb begin
        slot_free = 1'b1;
        load0     = 1'b0;
        load1     = 1'b0;
        if (in_sel) begin
            slot_free = !out1_valid || out1_ready;
            load1     = in_valid && slot_free;
        end else begin
            slot_free = !out0_valid || out0_ready;
            load0     = in_valid && slot_free;
        end
    end

    assign in_ready = slot_free;
    assign drain0   = out0_valid && out0_ready;
    assign drain1   = out1_valid && out1_ready;

    // Port 0 slot and delivery counter; a load wins over a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            cnt0       <= '0;
        end else begin
            if (load0) begin
                out0_valid <= 1'b1;
                out0_data  <= in_data;
            end else if (drain0) begin
                out0_valid <= 1'b0;
            end
            if (drain0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
        end
    end

    // Port 1 slot and delivery counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            cnt1       <= '0;
        end else begin
            if (load1) begin
                out1_valid <= 1'b1;
                out1_data  <= in_data;
            end else if (drain1) begin
                out1_valid <= 1'b0;
            end
            if (drain1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_one_to_two_reg.sv
// Self-checking bench for demux_one_to_two_reg: directed vector table plus
// hand-written sequences for reset, streaming, X select and counter wrap.
module tb_demux_one_to_two_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_ready;
    logic        out0_valid;
    logic [31:0] out0_data;
    logic        out0_ready;
    logic        out1_valid;
    logic [31:0] out1_data;
    logic        out1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    demux_one_to_two_reg #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        rdy;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] c1_before;
        logic [31:0] d1_before;

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset held for 3 cycles, then released with no traffic
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data", out0_data, 32'h0);
        chk("rst_out1_data", out1_data, 32'h0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);

        // Steering, then back-pressure isolation on port 0
        //           v     sel   data          r0    r1    rdy   v0    d0            v1    d1            c0  c1
        vecs[0] = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h00000000, 16'd0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h22222222, 16'd1, 16'd0};
        vecs[2] = '{1'b1, 1'b0, 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0, 32'h22222222, 16'd1, 16'd1};
        vecs[3] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33333333, 1'b0, 32'h22222222, 16'd2, 16'd1};
        vecs[4] = '{1'b1, 1'b0, 32'hCAFE0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE0000, 1'b0, 32'h22222222, 16'd2, 16'd1};
        vecs[5] = '{1'b1, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE0000, 1'b0, 32'h22222222, 16'd2, 16'd1};
        vecs[6] = '{1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE0000, 1'b1, 32'hA5A5A5A5, 16'd2, 16'd1};
        vecs[7] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE0000, 1'b0, 32'hA5A5A5A5, 16'd2, 16'd2};
        vecs[8] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE0000, 1'b0, 32'hA5A5A5A5, 16'd2, 16'd2};
        vecs[9] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE0000, 1'b0, 32'hA5A5A5A5, 16'd3, 16'd2};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            tick();
            chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].v0));
            chk($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].d0);
            chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].v1));
            chk($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].d1);
            chk($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].c0));
            chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].c1));
        end

        // Eight back-to-back words to port 1: drain and load in the same cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b1);
            #1;
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("stream%0d_out1_valid", i), 32'(out1_valid), 32'd1);
            chk($sformatf("stream%0d_out1_data", i), out1_data, 32'h100 + 32'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("stream_end_out1_valid", 32'(out1_valid), 32'd0);
        chk("stream_end_cnt1", 32'(cnt1), 32'd10);
        chk("stream_end_cnt0", 32'(cnt0), 32'd3);

        // Unknown select routes to port 0 only
        drive(1'b1, 1'bx, 32'h0BADF00D, 1'b0, 1'b0);
        tick();
        chk("xsel_out0_valid", 32'(out0_valid), 32'd1);
        chk("xsel_out0_data", out0_data, 32'h0BADF00D);
        chk("xsel_out1_valid", 32'(out1_valid), 32'd0);
        chk("xsel_out1_data", out1_data, 32'h107);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();

        // Asynchronous reset discards a held word on port 1
        drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        chk("pre_rst_out1_valid", 32'(out1_valid), 32'd1);
        chk("pre_rst_out1_data", out1_data, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("async_rst_out1_data", out1_data, 32'h0);
        chk("async_rst_cnt1", 32'(cnt1), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d_out1_valid", i), 32'(out1_valid), 32'd0);
            chk($sformatf("post_rst%0d_cnt1", i), 32'(cnt1), 32'd0);
        end

        // Counter wrap on port 0: 65535 deliveries, then one more
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("wrap_cnt0_max", 32'(cnt0), 32'h0000FFFF);
        chk("wrap_cnt1_before", 32'(cnt1), 32'd0);
        chk("wrap_out0_data", out0_data, 32'd65534);
        c1_before = cnt1;
        d1_before = out1_data;
        drive(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("wrap_cnt0_zero", 32'(cnt0), 32'h0);
        chk("wrap_cnt1_after", 32'(cnt1), 32'(c1_before));
        chk("wrap_out1_data", out1_data, d1_before);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
